main_control_fsm: RTL and testbench
===================================

Name: main_control_fsm

Overview:
Multicycle RISC-V main controller: the producer side of the alu_op interface consumed by alu_control. It decodes op[6:0] through a Moore state machine and sequences fetch, decode, execute, memory and writeback. It drives all datapath enables and muxes, plus the 2-bit alu_op (00 add, 01 subtract, 10 funct-decoded). It sits between the instruction register and the multicycle datapath, alongside alu_control.

Parameters:
SUPPORT_BNE  1  1: the branch condition honours funct3[0] (bne); 0: only beq, funct3 ignored
STATE_W  4  width of state register / state_dbg

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instruction opcode (IR[6:0])
funct3  in  3  instruction funct3 (IR[14:12])
zero  in  1  ALU zero flag, same cycle
pc_write  out  1  PC register enable
adr_src  out  1  memory address mux: 0 PC, 1 result
mem_write  out  1  data memory write enable
ir_write  out  1  IR/oldPC capture enable
reg_write  out  1  register file write enable
result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 register
alu_src_b  out  2  00 rs2 register, 01 immediate, 10 constant 4
alu_op  out  2  to alu_control: 00 add, 01 sub, 10 funct
imm_src  out  3  000 I, 001 S, 010 B, 011 J (combinational from op, every state)
illegal  out  1  sticky: unsupported opcode decoded
state_dbg  out  STATE_W  current state, for verification

Behaviour:
- Reset (rst_n low, asynchronous): state <= FETCH. While rst_n is low, every output except imm_src and state_dbg is forced to 0. illegal clears to 0.
- Reset mid-instruction aborts the instruction. The first cycle after release is FETCH.
- Outputs default to 0 unless listed for a state. pc_write = pc_update | (branch & (zero ^ (SUPPORT_BNE & funct3[0]))); this is the only Mealy term.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_update=1 -> DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch target).
  - op 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1101111 -> JAL.
  - 1100011 -> BRANCH.
  - any other op -> FAULT.
- MEMADR: a=10, b=01, alu_op=00 -> MEMREAD if op==0000011, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1 -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1 -> FETCH.
- EXECR: a=10, b=00, alu_op=10 -> ALUWB.
- EXECI: a=10, b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1 -> FETCH.
- FAULT: all enables 0, illegal=1. Remains in FAULT until reset.
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R/I 4, jal 4, branch 3.
- Illegal or unused state encodings -> FAULT.
- op and funct3 are only sampled in DECODE/MEMADR/BRANCH; changes in other states have no effect.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - state enum (FETCH..FAULT, fits STATE_W);
  - alu_op codes ALUOP_ADD/SUB/FUNCT;
  - imm_src, result_src and src_a/src_b encodings.
- Natural sub-module: imm_decoder (op -> imm_src, combinational, 000 for unknown op).

Test Plan:
- Release reset, op=0000011, zero=0 -> state_dbg sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH. reg_write=1 only in MEMWB, with result_src=01. alu_op=00 throughout.
- op=0110011 -> EXECR drives alu_op=10, a=10, b=00. ALUWB drives reg_write=1. 4 cycles back to FETCH. mem_write never 1.
- op=1100011, funct3=000: zero=1 -> pc_write=1 in BRANCH, alu_op=01; zero=0 -> pc_write=0. With funct3=001 and SUPPORT_BNE=1 the polarity inverts.
- op=0100011 -> MEMWRITE has mem_write=1, adr_src=1; imm_src=001 in every state; 4 cycles.
- op=1111111 -> DECODE goes to FAULT, illegal=1 and all enables 0 for 20 cycles. Pulsing rst_n low clears illegal and returns to FETCH.
- Assert rst_n low asynchronously in MEMREAD mid-cycle -> all enables 0 immediately. After release the state is FETCH with ir_write=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// riscv_ctrl_pkg : opcodes, state encoding and mux/alu_op codes shared by the
// multicycle RISC-V main controller.  Rev 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    FAULT    = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/main_control_fsm_imm_decoder.sv
// ============================================================================
// imm_decoder : opcode -> immediate format select, purely combinational.
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE: imm_src = IMM_I;
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      default:           imm_src = IMM_I;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/main_control_fsm.sv
// ============================================================================
// main_control_fsm : Moore sequencer for the multicycle RISC-V datapath; the
// only Mealy term is the branch-qualified pc_write.  Rev 1.0
// ============================================================================
`default_nettype none

module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int SUPPORT_BNE = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [2:0]         imm_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t     state, next_state;
  logic       illegal_q;

  logic       pc_update, branch;
  logic       adr_src_c, mem_write_c, ir_write_c, reg_write_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic       branch_taken;
  logic       unused_funct3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  illegal_q <= 1'b0;
    else if (next_state == FAULT) illegal_q <= 1'b1;
  end

  always_comb begin
    next_state   = FAULT;
    pc_update    = 1'b0;
    branch       = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    alu_op_c     = ALUOP_ADD;
    case (state)
      FETCH: begin
        ir_write_c   = 1'b1;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALU;
        pc_update    = 1'b1;
        next_state   = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while op is decoded.
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_JAL:            next_state = JAL;
          OP_BRANCH:         next_state = BRANCH;
          default:           next_state = FAULT;
        endcase
      end
      MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        next_state  = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src_c  = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        result_src_c = RES_RDATA;
        reg_write_c  = 1'b1;
        next_state   = FETCH;
      end
      MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        next_state  = FETCH;
      end
      EXECR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        alu_op_c    = ALUOP_FUNCT;
        next_state  = ALUWB;
      end
      EXECI: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_FUNCT;
        next_state  = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        next_state  = FETCH;
      end
      JAL: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_FOUR;
        pc_update   = 1'b1;
        next_state  = ALUWB;
      end
      BRANCH: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        alu_op_c    = ALUOP_SUB;
        branch      = 1'b1;
        next_state  = FETCH;
      end
      FAULT:   next_state = FAULT;
      default: next_state = FAULT;
    endcase
  end

  generate
    if (SUPPORT_BNE != 0) begin : g_bne
      assign branch_taken = zero ^ funct3[0];
    end else begin : g_beq_only
      assign branch_taken = zero;
    end
  endgenerate

  assign unused_funct3 = ^funct3;

  // Reset forces every control output low, even though state already reads FETCH.
  assign pc_write   = rst_n & (pc_update | (branch & branch_taken));
  assign adr_src    = rst_n & adr_src_c;
  assign mem_write  = rst_n & mem_write_c;
  assign ir_write   = rst_n & ir_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign result_src = rst_n ? result_src_c : 2'b00;
  assign alu_src_a  = rst_n ? alu_src_a_c  : 2'b00;
  assign alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
  assign alu_op     = rst_n ? alu_op_c     : 2'b00;
  assign illegal    = illegal_q;
  assign state_dbg  = STATE_W'(state);

  imm_decoder u_imm_decoder (
    .op      (op),
    .imm_src (imm_src)
  );

endmodule

`default_nettype wire

// File: tb/tb_main_control_fsm.sv
// ============================================================================
// tb_main_control_fsm : directed walk through every instruction class of the
// main controller with hand-derived control words.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_main_control_fsm;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_dbg;

  int tests = 0;
  int fails = 0;

  main_control_fsm #(.SUPPORT_BNE(1), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, a, b, alu_op}
  logic [12:0] ctrl;
  assign ctrl = {pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op};

  localparam logic [12:0] C_ZERO     = 13'b0_0_0_0_0_00_00_00_00;
  localparam logic [12:0] C_FETCH    = 13'b1_0_0_1_0_10_00_10_00;
  localparam logic [12:0] C_DECODE   = 13'b0_0_0_0_0_00_01_01_00;
  localparam logic [12:0] C_MEMADR   = 13'b0_0_0_0_0_00_10_01_00;
  localparam logic [12:0] C_MEMREAD  = 13'b0_1_0_0_0_00_00_00_00;
  localparam logic [12:0] C_MEMWB    = 13'b0_0_0_0_1_01_00_00_00;
  localparam logic [12:0] C_MEMWRITE = 13'b0_1_1_0_0_00_00_00_00;
  localparam logic [12:0] C_EXECR    = 13'b0_0_0_0_0_00_10_00_10;
  localparam logic [12:0] C_EXECI    = 13'b0_0_0_0_0_00_10_01_10;
  localparam logic [12:0] C_ALUWB    = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] C_JAL      = 13'b1_0_0_0_0_00_01_10_00;
  localparam logic [12:0] C_BR_NT    = 13'b0_0_0_0_0_00_10_00_01;
  localparam logic [12:0] C_BR_T     = 13'b1_0_0_0_0_00_10_00_01;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input state_t s, input logic [12:0] c);
    chk({tag, ".state"}, 32'(state_dbg), 32'(s));
    chk({tag, ".ctrl"},  32'(ctrl),      32'(c));
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    st("rst", FETCH, C_ZERO);
    chk("rst.illegal", 32'(illegal), 32'd0);
    op = OP_LOAD;
    chk("rst.imm_src_live", 32'(imm_src), 32'(IMM_I));
    nxt(); nxt();
    rst_n = 1'b1;
    #1;

    // lw: 5 cycles
    st("lw.fetch", FETCH, C_FETCH);
    nxt(); st("lw.decode", DECODE, C_DECODE);
    nxt(); st("lw.memadr", MEMADR, C_MEMADR);
    nxt(); st("lw.memread", MEMREAD, C_MEMREAD);
    nxt(); st("lw.memwb", MEMWB, C_MEMWB);
    nxt(); st("lw.back", FETCH, C_FETCH);

    // R-type: op changed during FETCH, sampled in DECODE
    op = OP_RTYPE;
    nxt(); st("r.decode", DECODE, C_DECODE);
    nxt(); st("r.execr", EXECR, C_EXECR);
    op = OP_LOAD;  // ignored outside DECODE/MEMADR/BRANCH
    nxt(); st("r.aluwb", ALUWB, C_ALUWB);
    nxt(); st("r.back", FETCH, C_FETCH);

    // I-type
    op = OP_ITYPE;
    nxt(); st("i.decode", DECODE, C_DECODE);
    nxt(); st("i.execi", EXECI, C_EXECI);
    nxt(); st("i.aluwb", ALUWB, C_ALUWB);
    nxt(); st("i.back", FETCH, C_FETCH);

    // Branch: zero and funct3 act combinationally in BRANCH
    op = OP_BRANCH; funct3 = 3'b000; zero = 1'b1;
    nxt(); st("br.decode", DECODE, C_DECODE);
    chk("br.imm_src", 32'(imm_src), 32'(IMM_B));
    nxt(); st("beq.z1", BRANCH, C_BR_T);
    zero = 1'b0; #1;
    chk("beq.z0.ctrl", 32'(ctrl), 32'(C_BR_NT));
    funct3 = 3'b001; #1;
    chk("bne.z0.ctrl", 32'(ctrl), 32'(C_BR_T));
    zero = 1'b1; #1;
    chk("bne.z1.ctrl", 32'(ctrl), 32'(C_BR_NT));
    nxt(); st("br.back", FETCH, C_FETCH);
    funct3 = 3'b000; zero = 1'b0;

    // sw: imm_src S in every state
    op = OP_STORE;
    #1; chk("sw.imm.fetch", 32'(imm_src), 32'(IMM_S));
    nxt(); st("sw.decode", DECODE, C_DECODE);
    chk("sw.imm.decode", 32'(imm_src), 32'(IMM_S));
    nxt(); st("sw.memadr", MEMADR, C_MEMADR);
    chk("sw.imm.memadr", 32'(imm_src), 32'(IMM_S));
    nxt(); st("sw.memwrite", MEMWRITE, C_MEMWRITE);
    chk("sw.imm.memwrite", 32'(imm_src), 32'(IMM_S));
    nxt(); st("sw.back", FETCH, C_FETCH);

    // jal
    op = OP_JAL;
    nxt(); st("jal.decode", DECODE, C_DECODE);
    chk("jal.imm_src", 32'(imm_src), 32'(IMM_J));
    nxt(); st("jal.jal", JAL, C_JAL);
    nxt(); st("jal.aluwb", ALUWB, C_ALUWB);
    nxt(); st("jal.back", FETCH, C_FETCH);

    // Illegal opcode: sticky FAULT
    op = 7'b1111111;
    nxt(); st("ill.decode", DECODE, C_DECODE);
    chk("ill.pre", 32'(illegal), 32'd0);
    for (int i = 0; i < 20; i++) begin
      nxt();
      st("ill.fault", FAULT, C_ZERO);
      chk("ill.flag", 32'(illegal), 32'd1);
      op = (i % 2 == 0) ? OP_RTYPE : OP_LOAD;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ill.rst.flag", 32'(illegal), 32'd0);
    st("ill.rst", FETCH, C_ZERO);
    nxt();
    rst_n = 1'b1;
    #1; st("ill.after", FETCH, C_FETCH);

    // Async reset mid-MEMREAD
    op = OP_LOAD;
    nxt(); st("ar.decode", DECODE, C_DECODE);
    nxt(); st("ar.memadr", MEMADR, C_MEMADR);
    nxt(); st("ar.memread", MEMREAD, C_MEMREAD);
    #2 rst_n = 1'b0;
    #1; st("ar.asserted", FETCH, C_ZERO);
    nxt();
    st("ar.held", FETCH, C_ZERO);
    rst_n = 1'b1;
    #1; st("ar.release", FETCH, C_FETCH);
    nxt(); st("ar.decode2", DECODE, C_DECODE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
